// File: rtl/seg7_pkg.sv
// Shared constants, conversion state type and saturation helper for the 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS          = 4;
  localparam int unsigned NIBBLE_W            = 4;
  localparam int unsigned VALUE_W             = 16;
  localparam logic [15:0] BCD_MAX             = 16'd9999;
  localparam int unsigned DEFAULT_REFRESH_DIV = 50000;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} conv_state_e;

  function automatic logic [VALUE_W-1:0] saturate_bcd(input logic [VALUE_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble converter: 16 shift iterations, then one commit cycle with done_o high.
module seg7_bin2bcd
  import seg7_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [VALUE_W-1:0] bcd_o
);

  conv_state_e        state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [VALUE_W-1:0] bcd_q, bcd_d;
  logic [VALUE_W-1:0] adj;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    adj     = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Input is saturated to 9999, so the top BCD bit never carries out.
        {bcd_d, bin_d} = {adj[VALUE_W-2:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StCommit);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches a display value and dot mask, then scans the four digits one slot at a time.
// Define SEG7_SCAN_BCD_CONV_EN to convert the loaded binary value to decimal before display.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int unsigned DIV_W       = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [VALUE_W-1:0]    VALUE_IN,
  input  logic [NUM_DIGITS-1:0] DOT_MASK_IN,
  input  logic                  LOAD_IN,
  output logic                  BUSY_OUT,
  output logic [1:0]            SEG_SELECT_OUT,
  output logic [NIBBLE_W-1:0]   BIN_OUT,
  output logic                  DOT_OUT
);

  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic                  tick;
  logic [1:0]            idx_q, idx_d;
  logic [VALUE_W-1:0]    disp_q, disp_d;
  logic [NUM_DIGITS-1:0] dot_q, dot_d;
  logic [NIBBLE_W-1:0]   bin_q;
  logic                  dot_out_q;

  assign tick  = (cnt_q == DIV_W'(REFRESH_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign idx_d = tick ? idx_q + 2'd1 : idx_q;

`ifdef SEG7_SCAN_BCD_CONV_EN
  logic                  accept;
  logic                  start_q, busy_q, busy_d;
  logic [VALUE_W-1:0]    cap_q, cap_d;
  logic [NUM_DIGITS-1:0] cap_dot_q, cap_dot_d;
  logic                  conv_busy, conv_done;
  logic [VALUE_W-1:0]    conv_bcd;

  // A pending start also blocks acceptance so a held LOAD_IN cannot restart the converter.
  assign accept = LOAD_IN & ~busy_q & ~start_q & ~conv_busy;

  always_comb begin
    cap_d     = accept ? saturate_bcd(VALUE_IN) : cap_q;
    cap_dot_d = accept ? DOT_MASK_IN : cap_dot_q;
    busy_d    = start_q | (busy_q & ~conv_done);
    disp_d    = conv_done ? conv_bcd : disp_q;
    dot_d     = conv_done ? cap_dot_q : dot_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      cap_q     <= '0;
      cap_dot_q <= '0;
    end else begin
      start_q   <= accept;
      busy_q    <= busy_d;
      cap_q     <= cap_d;
      cap_dot_q <= cap_dot_d;
    end
  end

  seg7_bin2bcd u_bin2bcd (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .start_i (start_q),
    .bin_i   (cap_q),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign BUSY_OUT = busy_q;
`else
  always_comb begin
    disp_d = LOAD_IN ? VALUE_IN : disp_q;
    dot_d  = LOAD_IN ? DOT_MASK_IN : dot_q;
  end

  assign BUSY_OUT = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      dot_q     <= '0;
      bin_q     <= '0;
      dot_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      dot_q     <= dot_d;
      // Indexed by the next digit so select, nibble and dot all change on one edge.
      bin_q     <= disp_q[{idx_d, 2'b00} +: NIBBLE_W];
      dot_out_q <= dot_q[idx_d];
    end
  end

  assign SEG_SELECT_OUT = idx_q;
  assign BIN_OUT        = bin_q;
  assign DOT_OUT        = dot_out_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver; follows SEG7_SCAN_BCD_CONV_EN for the expected display format.
module tb_seg7_scan_driver;

  localparam int unsigned DIV = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] VALUE_IN = '0;
  logic [3:0]  DOT_MASK_IN = '0;
  logic        LOAD_IN = 1'b0;
  logic        BUSY_OUT;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned ref_cnt = 0;
  int unsigned ref_idx = 0;
  logic [15:0] cur_val = '0;
  logic [3:0]  cur_dot = '0;

  always #5 CLK = ~CLK;

  seg7_scan_driver #(
    .REFRESH_DIV (DIV),
    .DIV_W       (4)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .VALUE_IN       (VALUE_IN),
    .DOT_MASK_IN    (DOT_MASK_IN),
    .LOAD_IN        (LOAD_IN),
    .BUSY_OUT       (BUSY_OUT),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .BIN_OUT        (BIN_OUT),
    .DOT_OUT        (DOT_OUT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; tracks the expected digit index alongside the DUT.
  task automatic step();
    @(posedge CLK);
    if (!RESET_N) begin
      ref_cnt = 0;
      ref_idx = 0;
    end else if (ref_cnt == DIV - 1) begin
      ref_cnt = 0;
      ref_idx = (ref_idx + 1) % 4;
    end else begin
      ref_cnt++;
    end
    #1;
  endtask

  function automatic logic [15:0] shown(input logic [15:0] v);
`ifdef SEG7_SCAN_BCD_CONV_EN
    int unsigned s;
    s = (v > 16'd9999) ? 9999 : int'(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
`else
    return v;
`endif
  endfunction

  task automatic check_frame(input string tag);
    for (int i = 0; i < 16; i++) begin
      step();
      check({tag, "_sel"}, 32'(SEG_SELECT_OUT), 32'(ref_idx));
      check({tag, "_bin"}, 32'(BIN_OUT), 32'(cur_val[ref_idx*4 +: 4]));
      check({tag, "_dot"}, 32'(DOT_OUT), 32'(cur_dot[ref_idx]));
      check({tag, "_busy"}, 32'(BUSY_OUT), 32'd0);
    end
  endtask

  task automatic load(input string tag, input logic [15:0] val, input logic [3:0] mask,
                      input bit inject);
    VALUE_IN    = val;
    DOT_MASK_IN = mask;
    LOAD_IN     = 1'b1;
    step();
    LOAD_IN = 1'b0;
    check({tag, "_busy_acc"}, 32'(BUSY_OUT), 32'd0);
    check({tag, "_old_acc"}, 32'(BIN_OUT), 32'(cur_val[ref_idx*4 +: 4]));
`ifdef SEG7_SCAN_BCD_CONV_EN
    begin
      int unsigned n;
      bit          fell;
      n    = 0;
      fell = 1'b0;
      for (int i = 0; i < 40 && !fell; i++) begin
        if (inject && i == 4) begin
          VALUE_IN    = 16'd42;
          DOT_MASK_IN = 4'hF;
          LOAD_IN     = 1'b1;
        end
        if (inject && i == 5) LOAD_IN = 1'b0;
        step();
        if (BUSY_OUT) n++;
        else fell = 1'b1;
        check({tag, "_old"}, 32'(BIN_OUT), 32'(cur_val[ref_idx*4 +: 4]));
        check({tag, "_olddot"}, 32'(DOT_OUT), 32'(cur_dot[ref_idx]));
      end
      LOAD_IN = 1'b0;
      check({tag, "_busy_len"}, n, 32'd17);
    end
`else
    check({tag, "_noinject"}, 32'(inject), 32'd0);
`endif
    cur_val = shown(val);
    cur_dot = mask;
    check_frame(tag);
  endtask

  initial begin
    repeat (2) step();
    check("rst_sel", 32'(SEG_SELECT_OUT), 32'd0);
    check("rst_bin", 32'(BIN_OUT), 32'd0);
    check("rst_dot", 32'(DOT_OUT), 32'd0);
    check("rst_busy", 32'(BUSY_OUT), 32'd0);
    RESET_N = 1'b1;
    ref_cnt = 0;
    ref_idx = 0;
    repeat (4) step();
    check("first_tick_sel", 32'(SEG_SELECT_OUT), 32'd1);
    check_frame("scan");

`ifdef SEG7_SCAN_BCD_CONV_EN
    load("bcd1234", 16'd1234, 4'b0010, 1'b0);
    load("bcd_sat", 16'd65535, 4'b1000, 1'b0);
    load("bcd_zero", 16'd0, 4'b0001, 1'b0);
    load("bcd_9999", 16'd9999, 4'b0100, 1'b0);
    load("bcd_busyld", 16'd1234, 4'b0011, 1'b1);
`else
    load("hex_a5c3", 16'hA5C3, 4'b0100, 1'b0);
    // Held LOAD_IN reloads on every edge; the last value wins.
    VALUE_IN    = 16'h1111;
    DOT_MASK_IN = 4'b0001;
    LOAD_IN     = 1'b1;
    step();
    VALUE_IN    = 16'h2222;
    DOT_MASK_IN = 4'b1000;
    step();
    LOAD_IN = 1'b0;
    check("held_first_bin", 32'(BIN_OUT), 32'd1);
    cur_val = 16'h2222;
    cur_dot = 4'b1000;
    check_frame("held");
`endif

    VALUE_IN    = 16'h4321;
    DOT_MASK_IN = 4'hF;
    LOAD_IN     = 1'b1;
    step();
    LOAD_IN = 1'b0;
    repeat (6) step();
    RESET_N = 1'b0;
    #1;
    check("arst_sel", 32'(SEG_SELECT_OUT), 32'd0);
    check("arst_bin", 32'(BIN_OUT), 32'd0);
    check("arst_dot", 32'(DOT_OUT), 32'd0);
    check("arst_busy", 32'(BUSY_OUT), 32'd0);
    RESET_N = 1'b1;
    ref_cnt = 0;
    ref_idx = 0;
    cur_val = '0;
    cur_dot = '0;
    check_frame("post_rst");
    load("post_rst_load", 16'h0056, 4'b0110, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Upstream feeder for the 4-digit 7-segment decoder. Latches a 16-bit display value and a 4-bit dot mask via a load handshake, then time-multiplexes the four digits. On each digit it emits a 2-bit select, a 4-bit nibble and a dot bit, which the decoder turns into anode and cathode drive. It can optionally convert binary to BCD so scores display in decimal.

Parameters:
REFRESH_DIV, 50000, CLK cycles per digit slot (100 MHz -> 2 kHz digit rate, 500 Hz frame); legal range >= 2
DIV_W, 16, prescaler width; must satisfy 2^DIV_W >= REFRESH_DIV

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
VALUE_IN  in  16  value to display (hex nibbles; binary if BCD feature on)
DOT_MASK_IN  in  4  dot enable per digit, bit i -> digit i
LOAD_IN  in  1  load request, accepted when BUSY_OUT=0
BUSY_OUT  out  1  high while a load is being processed
SEG_SELECT_OUT  out  2  current digit index 0..3 (0 = rightmost)
BIN_OUT  out  4  nibble for current digit
DOT_OUT  out  1  dot for current digit, active high

Behaviour:
- Reset (async assert, sync release): prescaler=0, digit index=0, display reg=0, dot reg=0, SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, BUSY_OUT=0, FSM=IDLE. Reset mid-conversion aborts the conversion, and the display reg returns to 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. Tick is asserted on the cycle where count = REFRESH_DIV-1.
- Digit index: increments on tick and wraps 3->0. SEG_SELECT_OUT is the registered digit index.
- BIN_OUT and DOT_OUT: registered every cycle from display_reg[idx_next] and dot_reg[idx_next], where idx_next is the index being loaded on that same edge. Select, nibble and dot therefore always change on the same edge. A display reg update becomes visible on the following edge without waiting for a tick.
- Load handshake: LOAD_IN is sampled on a rising edge with BUSY_OUT=0 -> VALUE_IN and DOT_MASK_IN are captured. LOAD_IN while BUSY_OUT=1 is ignored (no queuing). LOAD_IN held high reloads each cycle BUSY_OUT is 0.
- Feature off: captured value is written to the display reg on the accept edge. BUSY_OUT stays 0. Latency accept -> BIN_OUT = 1 cycle.
- Dot reg: committed in the same cycle as the display reg.
- Scanning: continues uninterrupted during loads. The prescaler is never reset by a load.

Optional Feature:
SEG7_SCAN_BCD_CONV_EN
- Defined:
  - VALUE_IN is treated as unsigned binary and saturated to 9999 before conversion.
  - Conversion is a sequential double-dabble. FSM: IDLE -> SHIFT (16 iterations; each iteration adds 3 to any BCD digit >= 5, then shifts left by 1) -> COMMIT -> IDLE.
  - BUSY_OUT goes to 1 on the edge after accept and returns to 0 on the COMMIT edge. COMMIT also writes the display reg and dot reg.
  - Accept to commit is exactly 18 edges.
  - Display keeps the old value throughout the conversion.
- Undefined: pure hex pass-through as described above; no FSM is instantiated.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=4, NIBBLE_W=4, VALUE_W=16
  - BCD_MAX=16'd9999, DEFAULT_REFRESH_DIV=50000
  - conversion state enum (IDLE, SHIFT, COMMIT)
- One sub-module, seg7_bin2bcd (start/busy/done, 16-bit in, 16-bit BCD out), instantiated only under SEG7_SCAN_BCD_CONV_EN.
- The scan/prescaler logic stays in the top module.

Test Plan:
- Reset scan (REFRESH_DIV=4): release reset, no load -> SEG_SELECT_OUT steps 0,1,2,3,0 every 4 cycles; BIN_OUT=0; DOT_OUT=0.
- Hex load (feature off): VALUE_IN=16'hA5C3, DOT_MASK_IN=4'b0100, 1-cycle LOAD_IN -> BIN_OUT = 3,C,5,A for select 0..3; DOT_OUT=1 only at select 2; BUSY_OUT never 1.
- BCD load (feature on): VALUE_IN=1234 -> BUSY_OUT high for 17 cycles, then BIN_OUT = 4,3,2,1 per select; old value shown until commit.
- BCD saturation/boundaries: VALUE_IN=65535 -> digits 9,9,9,9; VALUE_IN=0 -> 0,0,0,0; VALUE_IN=9999 -> 9,9,9,9.
- Load while busy: second LOAD_IN with 16'd42 at cycle 5 of a 1234 conversion -> ignored; display ends at 1234.
- Async reset mid-conversion: drop RESET_N for 1 ns during SHIFT -> all outputs 0 immediately; after release the display shows 0 and a new load works normally.
